// File: rtl/perceptron_train_ctrl.sv
// Perceptron training sequencer: walks the sample table epoch by epoch and issues every FP16 op
// to a shared external FPU over req/ack. Define PERCEPTRON_EARLY_STOP_EN to stop on an error-free epoch.
module perceptron_train_ctrl #(
  parameter int          N_SAMPLES  = 4,
  parameter int          MAX_EPOCHS = 32,
  parameter logic [15:0] ETA        = 16'h3800
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [15:0]                  w0_init,
  input  logic [15:0]                  w1_init,
  input  logic [15:0]                  w2_init,
  output logic [$clog2(N_SAMPLES)-1:0] samp_idx,
  input  logic [15:0]                  samp_in1,
  input  logic [15:0]                  samp_in2,
  input  logic [15:0]                  samp_d,
  output logic                         fpu_req,
  output logic [1:0]                   fpu_op,
  output logic [15:0]                  fpu_a,
  output logic [15:0]                  fpu_b,
  input  logic                         fpu_ack,
  input  logic [15:0]                  fpu_res,
  output logic [15:0]                  w0,
  output logic [15:0]                  w1,
  output logic [15:0]                  w2,
  output logic [N_SAMPLES-1:0]         result,
  output logic [7:0]                   epoch_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         converged
);

  localparam int IW = $clog2(N_SAMPLES);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [3:0] {
    IDLE, LOAD, MUL1, MUL2, ADD1, ADD2, CLASS, UPD_M1, UPD_M2,
    UPD_W1, UPD_W2, UPD_W0, NEXT, EPOCH, FIN
  } state_t;

  state_t         state_reg, state_next;
  logic [15:0]    x1_reg, x1_next, x2_reg, x2_next, d_reg, d_next;
  logic [15:0]    p1_reg, p1_next, p2_reg, p2_next, acc_reg, acc_next;
  logic           err_reg, err_next;
  logic           fpu_req_next;
  logic [1:0]     fpu_op_next;
  logic [15:0]    fpu_a_next, fpu_b_next;
  logic [15:0]    w0_next, w1_next, w2_next;
  logic [N_SAMPLES-1:0] result_next;
  logic [7:0]     epoch_cnt_next;
  logic [IW-1:0]  samp_idx_next;
  logic           busy_next, done_next, converged_next;

  logic           op_state;
  logic [1:0]     op_sel;
  logic [15:0]    a_sel, b_sel;
  logic           dbit, y, op_done, last_epoch, stop;
  logic [1:0]     upd_op;

  assign dbit       = ~d_reg[15] & (d_reg[14:0] != 15'd0);
  assign y          = ~acc_reg[15];
  assign upd_op     = dbit ? OP_ADD : OP_SUB;
  assign op_done    = fpu_req & fpu_ack;
  assign last_epoch = (epoch_cnt + 8'd1) == 8'(MAX_EPOCHS);
`ifdef PERCEPTRON_EARLY_STOP_EN
  assign stop = last_epoch | ~err_reg;
`else
  assign stop = last_epoch;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      x1_reg    <= '0;  x2_reg <= '0;  d_reg   <= '0;
      p1_reg    <= '0;  p2_reg <= '0;  acc_reg <= '0;
      err_reg   <= 1'b0;
      fpu_req   <= 1'b0; fpu_op <= '0; fpu_a <= '0; fpu_b <= '0;
      w0        <= '0;  w1 <= '0;  w2 <= '0;
      result    <= '0;  epoch_cnt <= '0; samp_idx <= '0;
      busy      <= 1'b0; done <= 1'b0; converged <= 1'b0;
    end else begin
      state_reg <= state_next;
      x1_reg    <= x1_next;  x2_reg <= x2_next;  d_reg   <= d_next;
      p1_reg    <= p1_next;  p2_reg <= p2_next;  acc_reg <= acc_next;
      err_reg   <= err_next;
      fpu_req   <= fpu_req_next; fpu_op <= fpu_op_next;
      fpu_a     <= fpu_a_next;   fpu_b  <= fpu_b_next;
      w0        <= w0_next;  w1 <= w1_next;  w2 <= w2_next;
      result    <= result_next; epoch_cnt <= epoch_cnt_next; samp_idx <= samp_idx_next;
      busy      <= busy_next; done <= done_next; converged <= converged_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    x1_next        = x1_reg;  x2_next = x2_reg;  d_next   = d_reg;
    p1_next        = p1_reg;  p2_next = p2_reg;  acc_next = acc_reg;
    err_next       = err_reg;
    fpu_req_next   = fpu_req; fpu_op_next = fpu_op;
    fpu_a_next     = fpu_a;   fpu_b_next  = fpu_b;
    w0_next        = w0;  w1_next = w1;  w2_next = w2;
    result_next    = result;
    epoch_cnt_next = epoch_cnt;
    samp_idx_next  = samp_idx;
    busy_next      = busy;
    done_next      = 1'b0;
    converged_next = converged;
    op_state       = 1'b0;
    op_sel         = OP_ADD;
    a_sel          = '0;
    b_sel          = '0;

    case (state_reg)
      IDLE: if (start) begin
        w0_next = w0_init; w1_next = w1_init; w2_next = w2_init;
        epoch_cnt_next = '0; result_next = '0; converged_next = 1'b0;
        samp_idx_next  = '0; err_next = 1'b0; busy_next = 1'b1;
        state_next     = LOAD;
      end
      LOAD: begin
        x1_next = samp_in1; x2_next = samp_in2; d_next = samp_d;
        state_next = MUL1;
      end
      MUL1: begin
        op_state = 1'b1; op_sel = OP_MUL; a_sel = w1; b_sel = x1_reg;
        if (op_done) begin p1_next = fpu_res; state_next = MUL2; end
      end
      MUL2: begin
        op_state = 1'b1; op_sel = OP_MUL; a_sel = w2; b_sel = x2_reg;
        if (op_done) begin p2_next = fpu_res; state_next = ADD1; end
      end
      ADD1: begin
        op_state = 1'b1; op_sel = OP_ADD; a_sel = p1_reg; b_sel = p2_reg;
        if (op_done) begin acc_next = fpu_res; state_next = ADD2; end
      end
      ADD2: begin
        op_state = 1'b1; op_sel = OP_ADD; a_sel = w0; b_sel = acc_reg;
        if (op_done) begin acc_next = fpu_res; state_next = CLASS; end
      end
      CLASS: begin
        result_next[samp_idx] = y;
        if (y == dbit) state_next = NEXT;
        else begin err_next = 1'b1; state_next = UPD_M1; end
      end
      // p1/p2 are reused to hold the ETA-scaled inputs during an update
      UPD_M1: begin
        op_state = 1'b1; op_sel = OP_MUL; a_sel = ETA; b_sel = x1_reg;
        if (op_done) begin p1_next = fpu_res; state_next = UPD_M2; end
      end
      UPD_M2: begin
        op_state = 1'b1; op_sel = OP_MUL; a_sel = ETA; b_sel = x2_reg;
        if (op_done) begin p2_next = fpu_res; state_next = UPD_W1; end
      end
      UPD_W1: begin
        op_state = 1'b1; op_sel = upd_op; a_sel = w1; b_sel = p1_reg;
        if (op_done) begin w1_next = fpu_res; state_next = UPD_W2; end
      end
      UPD_W2: begin
        op_state = 1'b1; op_sel = upd_op; a_sel = w2; b_sel = p2_reg;
        if (op_done) begin w2_next = fpu_res; state_next = UPD_W0; end
      end
      UPD_W0: begin
        op_state = 1'b1; op_sel = upd_op; a_sel = w0; b_sel = ETA;
        if (op_done) begin w0_next = fpu_res; state_next = NEXT; end
      end
      NEXT: begin
        if (samp_idx == IW'(N_SAMPLES - 1)) state_next = EPOCH;
        else begin samp_idx_next = samp_idx + 1'b1; state_next = LOAD; end
      end
      EPOCH: begin
        epoch_cnt_next = epoch_cnt + 8'd1;
        converged_next = ~err_reg;
        err_next       = 1'b0;
        samp_idx_next  = '0;
        if (stop) begin
          done_next = 1'b1; busy_next = 1'b0; state_next = FIN;
        end else begin
          state_next = LOAD;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Request is raised one cycle after entering an op state and dropped right after the ack.
    if (op_state) begin
      if (!fpu_req) begin
        fpu_req_next = 1'b1;
        fpu_op_next  = op_sel;
        fpu_a_next   = a_sel;
        fpu_b_next   = b_sel;
      end else if (fpu_ack) begin
        fpu_req_next = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Randomised bench for perceptron_train_ctrl: an FP16 FPU model with optional random ack delay,
// and a training reference model built on real-valued FP16 arithmetic.
`timescale 1ns/1ps
module tb_perceptron_train_ctrl;

  localparam int          N         = 4;
  localparam int          MAXE      = 32;
  localparam logic [15:0] ETA_V     = 16'h3800;
  localparam int          RUN_LIMIT = 20000;
`ifdef PERCEPTRON_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
  localparam int OR_EPOCHS = 3;
`else
  localparam bit EARLY = 1'b0;
  localparam int OR_EPOCHS = MAXE;
`endif

  logic        clk, rst, start;
  logic [15:0] w0_init, w1_init, w2_init;
  logic [1:0]  samp_idx;
  logic [15:0] samp_in1, samp_in2, samp_d;
  logic        fpu_req, fpu_ack;
  logic [1:0]  fpu_op;
  logic [15:0] fpu_a, fpu_b, fpu_res;
  logic [15:0] w0, w1, w2;
  logic [N-1:0] result;
  logic [7:0]  epoch_cnt;
  logic        busy, done, converged;

  logic [15:0] tab_in1 [N];
  logic [15:0] tab_in2 [N];
  logic [15:0] tab_d   [N];

  int n_cmp = 0;
  int n_bad = 0;

  // FPU model / handshake monitor state
  bit          rand_delay = 0;
  bit          stray_ack  = 0;
  bit          ack_seen, req_prev;
  logic [1:0]  op_prev;
  logic [15:0] a_prev, b_prev;
  int          wait_left = -1;
  int          viol = 0;

  // reference model outputs
  logic [15:0]  m_w0, m_w1, m_w2;
  logic [N-1:0] m_res;
  int           m_ep;
  bit           m_conv;

  assign samp_in1 = tab_in1[samp_idx];
  assign samp_in2 = tab_in2[samp_idx];
  assign samp_d   = tab_d[samp_idx];

  perceptron_train_ctrl #(.N_SAMPLES(N), .MAX_EPOCHS(MAXE), .ETA(ETA_V)) dut (
    .clk(clk), .rst(rst), .start(start),
    .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init),
    .samp_idx(samp_idx), .samp_in1(samp_in1), .samp_in2(samp_in2), .samp_d(samp_d),
    .fpu_req(fpu_req), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_ack(fpu_ack), .fpu_res(fpu_res),
    .w0(w0), .w1(w1), .w2(w2), .result(result), .epoch_cnt(epoch_cnt),
    .busy(busy), .done(done), .converged(converged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real p = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
    else        for (int i = 0; i < -k; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real f = real'(int'(h[9:0]));
    real v;
    if (e == 31)     v = 1.0e6;
    else if (e == 0) v = f * pow2(-24);
    else             v = (1024.0 + f) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  // Round-to-nearest-even conversion; sums and products of FP16 values are exact in a real.
  function automatic logic [15:0] real_to_fp16(input real r);
    logic s;
    real a, m, fr;
    int k;
    longint q;
    logic [4:0] e;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a == 0.0) return 16'h0000;
    if (a >= 65520.0) return {s, 15'h7C00};
    k = 0;
    while (a >= pow2(k + 1)) k++;
    while (a < pow2(k)) k--;
    if (k < -14) m = a / pow2(-24);
    else         m = a / pow2(k - 10);
    q  = longint'($floor(m));
    fr = m - $floor(m);
    if (fr > 0.5 || (fr == 0.5 && q[0])) q++;
    if (k < -14) return {s, q[14:0]};
    if (q == 2048) begin q = 1024; k++; end
    if (k > 15) return {s, 15'h7C00};
    e = 5'(k + 15);
    return {s, e, q[9:0]};
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    return real_to_fp16(fp16_to_real(a) + fp16_to_real(b));
  endfunction
  function automatic logic [15:0] fp_sub(input logic [15:0] a, input logic [15:0] b);
    return real_to_fp16(fp16_to_real(a) - fp16_to_real(b));
  endfunction
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    return real_to_fp16(fp16_to_real(a) * fp16_to_real(b));
  endfunction

  // External FPU: answers each request after 0 (or random 0..5) extra cycles and
  // records any change of op/operands while a request is outstanding.
  initial begin
    fpu_ack = 1'b0;
    fpu_res = 16'h0000;
    req_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ack_seen = fpu_ack;
      if (rst) begin
        fpu_ack = 1'b0; req_prev = 1'b0; wait_left = -1;
      end else begin
        if (req_prev && !ack_seen &&
            (!fpu_req || fpu_op !== op_prev || fpu_a !== a_prev || fpu_b !== b_prev))
          viol++;
        fpu_ack = 1'b0;
        if (fpu_req && !ack_seen) begin
          if (wait_left < 0) wait_left = rand_delay ? int'($urandom_range(0, 5)) : 0;
          if (wait_left == 0) begin
            fpu_ack = 1'b1;
            case (fpu_op)
              2'b00:   fpu_res = fp_add(fpu_a, fpu_b);
              2'b01:   fpu_res = fp_sub(fpu_a, fpu_b);
              2'b10:   fpu_res = fp_mul(fpu_a, fpu_b);
              default: fpu_res = 16'h7E00;
            endcase
            wait_left = -1;
          end else begin
            wait_left--;
          end
        end else if (!fpu_req && stray_ack) begin
          fpu_ack = 1'b1; fpu_res = 16'h7BFF; stray_ack = 0;
        end
        req_prev = fpu_req; op_prev = fpu_op; a_prev = fpu_a; b_prev = fpu_b;
      end
    end
  end

  // Textbook perceptron rule over the table, each arithmetic step rounded to FP16.
  task automatic model_run(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2);
    logic [15:0] net, t1, t2;
    bit err, yb, db;
    m_w0 = i0; m_w1 = i1; m_w2 = i2; m_res = '0; m_ep = 0; m_conv = 0;
    do begin
      err = 0;
      for (int s = 0; s < N; s++) begin
        net = fp_add(m_w0, fp_add(fp_mul(m_w1, tab_in1[s]), fp_mul(m_w2, tab_in2[s])));
        yb  = !net[15];
        db  = (tab_d[s][15] == 1'b0) && (tab_d[s][14:0] != 15'd0);
        m_res[s] = yb;
        if (yb != db) begin
          err = 1;
          t1 = fp_mul(ETA_V, tab_in1[s]);
          t2 = fp_mul(ETA_V, tab_in2[s]);
          if (db) begin
            m_w1 = fp_add(m_w1, t1); m_w2 = fp_add(m_w2, t2); m_w0 = fp_add(m_w0, ETA_V);
          end else begin
            m_w1 = fp_sub(m_w1, t1); m_w2 = fp_sub(m_w2, t2); m_w0 = fp_sub(m_w0, ETA_V);
          end
        end
      end
      m_ep++;
      m_conv = !err;
    end while (!(m_ep == MAXE || (EARLY && !err)));
  endtask

  task automatic load_table(input logic [15:0] a [N], input logic [15:0] b [N], input logic [15:0] d [N]);
    for (int s = 0; s < N; s++) begin tab_in1[s] = a[s]; tab_in2[s] = b[s]; tab_d[s] = d[s]; end
  endtask

  task automatic load_or();
    load_table('{16'h0000, 16'h3C00, 16'h0000, 16'h3C00},
               '{16'h0000, 16'h0000, 16'h3C00, 16'h3C00},
               '{16'h0000, 16'h3C00, 16'h3C00, 16'h3C00});
  endtask

  task automatic load_xor();
    load_table('{16'h0000, 16'h3C00, 16'h0000, 16'h3C00},
               '{16'h0000, 16'h0000, 16'h3C00, 16'h3C00},
               '{16'h0000, 16'h3C00, 16'h3C00, 16'h0000});
  endtask

  function automatic logic [15:0] rand_val();
    int k = int'($urandom_range(0, 8));
    return real_to_fp16(real'(k - 4) * 0.25);
  endfunction

  task automatic load_random();
    logic [15:0] dset [5];
    dset = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h3800};
    for (int s = 0; s < N; s++) begin
      tab_in1[s] = rand_val();
      tab_in2[s] = rand_val();
      tab_d[s]   = dset[$urandom_range(0, 4)];
    end
  endtask

  task automatic run_train(input string tag, input logic [15:0] i0, input logic [15:0] i1,
                           input logic [15:0] i2, input bit hold);
    int cyc = 0;
    int dn = 0;
    model_run(i0, i1, i2);
    @(negedge clk);
    w0_init = i0; w1_init = i1; w2_init = i2; start = 1'b1;
    @(negedge clk);
    check_val({tag, "_busy_rise"}, 32'(busy), 32'd1);
    if (!hold) start = 1'b0;
    while (!done && cyc < RUN_LIMIT) begin @(negedge clk); cyc++; end
    start = 1'b0;
    check_val({tag, "_done_seen"}, 32'(done), 32'd1);
    check_val({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_val({tag, "_epochs"}, 32'(epoch_cnt), 32'(m_ep));
    check_val({tag, "_converged"}, 32'(converged), 32'(m_conv));
    check_val({tag, "_result"}, 32'(result), 32'(m_res));
    check_val({tag, "_w0"}, 32'(w0), 32'(m_w0));
    check_val({tag, "_w1"}, 32'(w1), 32'(m_w1));
    check_val({tag, "_w2"}, 32'(w2), 32'(m_w2));
    $display("run %s: epochs=%0d converged=%0d result=%b w0=%h w1=%h w2=%h",
             tag, epoch_cnt, converged, result, w0, w1, w2);
    repeat (20) begin @(negedge clk); if (done) dn++; end
    check_val({tag, "_extra_done"}, 32'(dn), 32'd0);
    check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_hs_stable"}, 32'(viol), 32'd0);
  endtask

  task automatic or_const_checks(input string tag);
    check_val({tag, "_or_epochs"}, 32'(epoch_cnt), 32'(OR_EPOCHS));
    check_val({tag, "_or_conv"}, 32'(converged), 32'd1);
    check_val({tag, "_or_result"}, 32'(result), 32'h0000000E);
    check_val({tag, "_or_w1"}, 32'(w1), 32'h00003A66);
    check_val({tag, "_or_w2"}, 32'(w2), 32'h00003A66);
  endtask

  initial begin
    int req_cnt, cyc;
    bit last;
    rst = 1'b1; start = 1'b0;
    w0_init = '0; w1_init = '0; w2_init = '0;
    load_or();
    repeat (3) @(negedge clk);
    check_val("rst_fpu_req", 32'(fpu_req), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_conv", 32'(converged), 32'd0);
    check_val("rst_epoch", 32'(epoch_cnt), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_w", {w0, w1}, 32'd0);
    check_val("rst_w2_idx", {14'd0, samp_idx, w2}, 32'd0);
    check_val("rst_fpu_ops", {14'd0, fpu_op, fpu_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // OR gate with a 1-cycle FPU, then with random ack delay
    rand_delay = 0;
    run_train("or_ack1", 16'h3A66, 16'h3A66, 16'h3A66, 0);
    or_const_checks("or_ack1");
    rand_delay = 1;
    run_train("or_rand", 16'h3A66, 16'h3A66, 16'h3A66, 0);
    or_const_checks("or_rand");

    // XOR never separates: runs to the epoch limit without converging
    load_xor();
    run_train("xor", 16'h3A66, 16'h3A66, 16'h3A66, 0);
    check_val("xor_epochs", 32'(epoch_cnt), 32'(MAXE));
    check_val("xor_conv", 32'(converged), 32'd0);

    for (int r = 0; r < 3; r++) begin
      load_random();
      run_train($sformatf("rand%0d", r), rand_val(), rand_val(), rand_val(), 0);
    end

    // reset while the w1 update request (7th op of sample 0) is outstanding
    rand_delay = 0;
    load_or();
    @(negedge clk);
    w0_init = 16'h3A66; w1_init = 16'h3A66; w2_init = 16'h3A66; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    req_cnt = 0; cyc = 0; last = 0;
    while (req_cnt < 7 && cyc < 500) begin
      if (fpu_req && !last) req_cnt++;
      last = fpu_req;
      if (req_cnt < 7) begin @(negedge clk); cyc++; end
    end
    check_val("w1upd_reached", 32'(req_cnt), 32'd7);
    check_val("w1upd_op_sub", 32'(fpu_op), 32'd1);
    check_val("w1upd_a", 32'(fpu_a), 32'h00003A66);
    check_val("w1upd_req_high", 32'(fpu_req), 32'd1);
    rst = 1'b1;
    #1;
    check_val("rst_async_req", 32'(fpu_req), 32'd0);
    check_val("rst_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_mid_w", {w0, w1}, 32'd0);
    check_val("rst_mid_misc", {epoch_cnt, result, 2'd0, samp_idx, 14'd0, fpu_op}, 32'd0);
    repeat (2) @(negedge clk);
    stray_ack = 1;
    repeat (4) @(negedge clk);
    check_val("stray_after_rst_busy", 32'(busy), 32'd0);
    check_val("stray_after_rst_req", 32'(fpu_req), 32'd0);
    check_val("stray_after_rst_w", {w0, w2}, 32'd0);
    run_train("after_rst", 16'h3A66, 16'h3A66, 16'h3A66, 0);
    or_const_checks("after_rst");

    // start held high for the whole run, then stray acks while idle
    rand_delay = 1;
    load_random();
    run_train("hold", rand_val(), rand_val(), rand_val(), 1);
    for (int i = 0; i < 3; i++) begin
      stray_ack = 1;
      repeat (3) @(negedge clk);
    end
    check_val("idle_stray_busy", 32'(busy), 32'd0);
    check_val("idle_stray_w01", {w0, w1}, {m_w0, m_w1});
    check_val("idle_stray_w2", 32'(w2), 32'(m_w2));
    check_val("idle_stray_epoch", 32'(epoch_cnt), 32'(m_ep));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/perceptron_train_ctrl.md
# perceptron_train_ctrl

Training sequencer for the 16-bit half-precision (FP16) perceptron neuron with two inputs plus a bias (weights w0 = bias, w1, w2). It walks a small sample table of (in1, in2, d) entries epoch by epoch. Forward pass and weight updates are issued as single operations to one shared external FP16 arithmetic unit over a req/ack handshake. The loop stops on convergence or on an epoch limit and exposes the trained weights and per-sample classifications.

## Interface
- `N_SAMPLES`, 4, number of training samples (2..16).
- `MAX_EPOCHS`, 32, epoch limit (1..255).
- `ETA`, 16'h3800, learning rate as FP16 (0.5).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin training; sampled only in IDLE.
- `w0_init`, `w1_init`, `w2_init`  in  16  initial FP16 weights, captured on accepted start.
- `samp_idx`  out  $clog2(N_SAMPLES)  sample table address.
- `samp_in1`, `samp_in2`, `samp_d`  in  16  FP16 sample fields; combinational read of `samp_idx`, valid same cycle.
- `fpu_req`  out  1  operation request.
- `fpu_op`  out  2  operation code: 00 add, 01 sub (a-b), 10 mul.
- `fpu_a`, `fpu_b`  out  16  operands.
- `fpu_ack`  in  1  one-cycle result-valid pulse.
- `fpu_res`  in  16  result, valid with `fpu_ack`.
- `w0`, `w1`, `w2`  out  16  current weights.
- `result`  out  N_SAMPLES  classification bits y of the most recent pass over each sample.
- `epoch_cnt`  out  8  epochs completed.
- `busy`  out  1  training in progress.
- `done`  out  1  one-cycle pulse at end of training.
- `converged`  out  1  last completed epoch had zero errors; held until next accepted start.

## Operation
- States: IDLE, LOAD, MUL1, MUL2, ADD1, ADD2, CLASS, UPD_M1, UPD_M2, UPD_W1, UPD_W2, UPD_W0, NEXT, EPOCH, FIN.
- IDLE: when `start`=1, capture the init weights and clear `epoch_cnt`, `result`, `converged`, sample index and error flag, then go to LOAD. `start` is ignored in every other state.
- LOAD: present the current `samp_idx`, latch x1, x2 and d. Then:
  - MUL1: p1 = w1*x1.
  - MUL2: p2 = w2*x2.
  - ADD1: s = p1+p2.
  - ADD2: net = w0+s.
- CLASS:
  - y = ~net[15]. A sign bit of 0 (including +0) gives 1; otherwise 0.
  - dbit = (samp_d[15]==0 && samp_d[14:0]!=0).
  - Write `result[idx]` = y.
  - If y==dbit, go to NEXT. Otherwise set the error flag and go to UPD_M1.
- Update sequence:
  - UPD_M1: t1 = ETA*x1.
  - UPD_M2: t2 = ETA*x2.
  - UPD_W1: w1 = w1 ± t1.
  - UPD_W2: w2 = w2 ± t2.
  - UPD_W0: w0 = w0 ± ETA.
  - Use add when dbit=1 (err=+1) and sub when dbit=0 (err=-1).
- NEXT: if idx==N_SAMPLES-1, go to EPOCH. Otherwise increment idx and go to LOAD.
- EPOCH:
  - Increment `epoch_cnt`.
  - Set `converged` = !error flag.
  - Clear the error flag and set idx to 0.
  - Stop condition per Configuration. If stopping, go to FIN; else go to LOAD.
- FIN: pulse `done` for 1 cycle, return to IDLE.
- Weights change only on `fpu_ack` in the UPD_W* states.
- No arithmetic is done locally. NaN/Inf from the FPU propagate unchecked.

## Timing
- Reset values:
  - `busy`, `done`, `converged`, `fpu_req` = 0.
  - `fpu_op`, `fpu_a`, `fpu_b`, `samp_idx`, `epoch_cnt`, `result` = 0.
  - `w0`, `w1`, `w2` = 0.
  - State = IDLE.
- Asserting `rst` mid-operation drops `fpu_req` immediately (asynchronous). A late `fpu_ack` after reset is ignored.
- `busy` rises the cycle after start is accepted. It falls in the same cycle `done` pulses.
- Handshake rules:
  - `fpu_req`, `fpu_op`, `fpu_a` and `fpu_b` are registered and held stable until `fpu_ack` is sampled high.
  - `fpu_req` deasserts the cycle after ack.
  - The next request is asserted no earlier than the cycle after ack. Back-to-back ops are 2 cycles each with a zero-wait FPU.
  - `fpu_ack` while `fpu_req`=0 is ignored.
- Per-sample cost with a 1-cycle FPU:
  - LOAD 1 + 4 ops + CLASS 1 + NEXT 1 = 11 cycles.
  - Add 5 ops (10 cycles) when an update is needed.
  - EPOCH adds 1 cycle.

## Configuration
- `PERCEPTRON_EARLY_STOP_EN` defined: stop at the first EPOCH where the error flag is 0, or when `epoch_cnt` reaches MAX_EPOCHS.
- Not defined: always run exactly MAX_EPOCHS epochs. `converged` still reflects the final epoch only.

## Test plan
- OR gate, EARLY_STOP on:
  - Setup: samples (0,0,0), (1,0,1), (0,1,1), (1,1,1) with 1.0=16'h3C00; all init weights 16'h3A66; ETA 16'h3800; FPU model with 1-cycle ack.
  - Required: `done` after `epoch_cnt`=3, `converged`=1, `result`=4'b1110 (bit i = sample i), w1=w2=16'h3A66, w0 = 16'h3A66 − 0.5 − 0.5 as computed by the FPU model.
- Same OR-gate run with EARLY_STOP off -> `epoch_cnt`=32 at `done`, weights identical to the EARLY_STOP-on result, `converged`=1.
- XOR table (d=0,1,1,0), MAX_EPOCHS=8 -> `done` with `epoch_cnt`=8, `converged`=0, `busy` low after `done`.
- Random FPU ack delay of 0–5 cycles -> `fpu_a`, `fpu_b`, `fpu_op` stable while `fpu_req`=1; final weights equal to the 1-cycle-ack run.
- `rst` pulsed mid UPD_W1 with `fpu_req`=1 -> `fpu_req` low in the same cycle; all outputs at reset values; a spurious ack 2 cycles later is ignored; a new `start` runs normally.
- `start` held high during training and stray `fpu_ack` pulses in IDLE -> no restart and no state change; exactly one `done` pulse.
